// File: rtl/weight_stream_reader.sv
// weight_stream_reader: walks the weight BRAM from address 0..N_WEIGHTS-1 and presents
// each word on a valid/ready stream through a 2-entry FIFO. Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module weight_stream_reader #(
  parameter int N_WEIGHTS = 28,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              ABORT,
  output logic              BUSY,
  output logic              DONE,
  output logic              BRAM_EN,
  output logic              BRAM_WE,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  input  logic [DATA_W-1:0] BRAM_DO,
  output logic [DATA_W-1:0] W_DATA,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic              W_LAST,
  output logic [ADDR_W-1:0] W_INDEX
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WEIGHTS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] iss_addr_q, iss_addr_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] hd_data_q, hd_data_d, tl_data_q, tl_data_d;
  logic [ADDR_W-1:0] hd_idx_q, hd_idx_d, tl_idx_q, tl_idx_d;
  logic              hd_last_q, hd_last_d, tl_last_q, tl_last_d;

  logic              w_valid, w_pop, w_push, w_credit_ok, w_issue, w_new_last;
  logic [ADDR_W-1:0] w_iss_addr;
  logic [2:0]        w_occ;

  assign w_valid     = (cnt_q != 2'd0);
  assign w_pop       = w_valid & W_READY;
  assign w_push      = en_q;
  assign w_new_last  = (addr_q == LAST_ADDR);
  // Occupancy after this edge, counting the read already in flight.
  assign w_occ       = ({1'b0, cnt_q} + {2'b00, en_q}) - {2'b00, w_pop};
  assign w_credit_ok = (w_occ < 3'd2);

  always_comb begin
    state_d    = state_q;
    iss_addr_d = iss_addr_q;
    en_d       = 1'b0;
    addr_d     = addr_q;
    done_d     = 1'b0;
    w_issue    = 1'b0;
    w_iss_addr = iss_addr_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d    = S_FETCH;
          iss_addr_d = '0;
          w_iss_addr = '0;
          w_issue    = w_credit_ok;
        end
      end
      S_FETCH: w_issue = w_credit_ok;
      S_DRAIN: begin
        if (w_pop && W_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (w_issue) begin
      en_d       = 1'b1;
      addr_d     = w_iss_addr;
      iss_addr_d = w_iss_addr + 1'b1;
      if (w_iss_addr == LAST_ADDR) state_d = S_DRAIN;
    end
    if (ABORT) begin
      state_d    = S_IDLE;
      en_d       = 1'b0;
      done_d     = 1'b0;
      iss_addr_d = '0;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    hd_data_d = hd_data_q;
    hd_idx_d  = hd_idx_q;
    hd_last_d = hd_last_q;
    tl_data_d = tl_data_q;
    tl_idx_d  = tl_idx_q;
    tl_last_d = tl_last_q;
    case ({w_push, w_pop})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) begin
          hd_data_d = BRAM_DO; hd_idx_d = addr_q; hd_last_d = w_new_last;
        end else begin
          tl_data_d = BRAM_DO; tl_idx_d = addr_q; tl_last_d = w_new_last;
        end
      end
      2'b01: begin
        cnt_d     = cnt_q - 2'd1;
        hd_data_d = tl_data_q; hd_idx_d = tl_idx_q; hd_last_d = tl_last_q;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          hd_data_d = BRAM_DO; hd_idx_d = addr_q; hd_last_d = w_new_last;
        end else begin
          hd_data_d = tl_data_q; hd_idx_d = tl_idx_q; hd_last_d = tl_last_q;
          tl_data_d = BRAM_DO;   tl_idx_d = addr_q;   tl_last_d = w_new_last;
        end
      end
      default: ;
    endcase
    if (ABORT) cnt_d = 2'd0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      iss_addr_q <= '0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      done_q     <= 1'b0;
      cnt_q      <= 2'd0;
      hd_data_q  <= '0;
      hd_idx_q   <= '0;
      hd_last_q  <= 1'b0;
      tl_data_q  <= '0;
      tl_idx_q   <= '0;
      tl_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      iss_addr_q <= iss_addr_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      hd_data_q  <= hd_data_d;
      hd_idx_q   <= hd_idx_d;
      hd_last_q  <= hd_last_d;
      tl_data_q  <= tl_data_d;
      tl_idx_q   <= tl_idx_d;
      tl_last_q  <= tl_last_d;
    end
  end

  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = done_q;
  assign BRAM_EN   = en_q;
  assign BRAM_WE   = 1'b0;
  assign BRAM_ADDR = addr_q;
  assign W_DATA    = hd_data_q;
  assign W_INDEX   = hd_idx_q;
  assign W_VALID   = w_valid;
  assign W_LAST    = hd_last_q & w_valid;

endmodule

`default_nettype wire
